// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial deserializer slice.
// SERIAL_PARITY_CHECK_EN appends an even-parity bit to every frame.
package serial_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

`ifdef SERIAL_PARITY_CHECK_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    function automatic int cnt_width(input int n);
        return $clog2(n);
    endfunction

    // Reduction XOR; callers zero-extend narrower frames.
    function automatic logic even_parity(input logic [63:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/serial_bit_counter.sv
// Modulo-N event counter with synchronous clear and a wrap strobe on the
// enabled cycle that rolls the count from N-1 back to 0.
module serial_bit_counter
    import serial_pkg::*;
#(
    parameter int N = 10,
    parameter int W = cnt_width(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         wrap
);

    logic at_top_s;

    assign at_top_s = (count == W'(N - 1));
    assign wrap     = en & ~clr & at_top_s;

    // Count qualified events; clear wins over enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= {W{1'b0}};
        end else if (clr) begin
            count <= {W{1'b0}};
        end else if (en) begin
            if (at_top_s) begin
                count <= {W{1'b0}};
            end else begin
                count <= count + W'(1);
            end
        end
    end

endmodule

// File: rtl/serial_deserializer.sv
// LSB-first serial-to-parallel receiver with one output holding register.
// SERIAL_PARITY_CHECK_EN: frames carry a trailing even-parity bit, reported on parity_err.
module serial_deserializer
    import serial_pkg::*;
#(
    parameter int SIZE = 10
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   sin,
    input  logic                                   sin_valid,
    input  logic                                   flush,
    output logic [SIZE-1:0]                        word_out,
    output logic                                   word_valid,
    input  logic                                   word_ready,
    output logic                                   overrun,
    output logic [cnt_width(SIZE+PAR_BITS)-1:0]    bit_cnt,
    output logic                                   parity_err
);

    localparam int FRAME = SIZE + PAR_BITS;
    localparam int CW    = cnt_width(FRAME);

    logic [FRAME-1:0] shift_r;
    logic [FRAME-1:0] frame_s;
    logic             complete_s;
    logic             perr_s;
    logic             load_s;
    logic             drop_s;
    out_state_t       state_r;
    out_state_t       next_state_s;

    // Incoming bit enters at the MSB so the first bit ends up in bit 0
    assign frame_s = {sin, shift_r[FRAME-1:1]};

`ifdef SERIAL_PARITY_CHECK_EN
    assign perr_s = even_parity(64'(frame_s));
`else
    assign perr_s = 1'b0;
`endif

    serial_bit_counter #(
        .N (FRAME),
        .W (CW)
    ) u_bit_counter (
        .clk   (clk),
        .rst   (rst),
        .en    (sin_valid),
        .clr   (flush),
        .count (bit_cnt),
        .wrap  (complete_s)
    );

    // Shift stage; flush discards the partial word including this cycle's bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_r <= {FRAME{1'b0}};
        end else if (flush) begin
            shift_r <= {FRAME{1'b0}};
        end else if (sin_valid) begin
            shift_r <= frame_s;
        end
    end

    // Output handoff state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= EMPTY;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next state: a completing word reloads when the old one leaves this cycle
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        drop_s       = 1'b0;
        case (state_r)
            EMPTY: begin
                if (complete_s) begin
                    load_s       = 1'b1;
                    next_state_s = FULL;
                end else begin
                    next_state_s = EMPTY;
                end
            end
            FULL: begin
                if (complete_s) begin
                    if (word_ready) begin
                        load_s = 1'b1;
                    end else begin
                        drop_s = 1'b1;
                    end
                    next_state_s = FULL;
                end else if (word_ready) begin
                    next_state_s = EMPTY;
                end else begin
                    next_state_s = FULL;
                end
            end
            default: begin
                next_state_s = EMPTY;
            end
        endcase
    end

    assign word_valid = (state_r == FULL);

    // Holding register for the delivered word and its parity status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_out   <= {SIZE{1'b0}};
            parity_err <= 1'b0;
        end else if (load_s) begin
            word_out   <= frame_s[SIZE-1:0];
            parity_err <= perr_s;
        end
    end

    // Sticky drop indicator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (drop_s) begin
            overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_serial_deserializer.sv
// Self-checking bench for serial_deserializer: vector table plus scoreboarded sequences.
module tb_serial_deserializer;

    localparam int SIZE = 10;
`ifdef SERIAL_PARITY_CHECK_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME = SIZE + PAR;
    localparam int CW    = $clog2(FRAME);

    logic            clk;
    logic            rst;
    logic            sin;
    logic            sin_valid;
    logic            flush;
    logic            word_ready;
    logic [SIZE-1:0] word_out;
    logic            word_valid;
    logic            overrun;
    logic [CW-1:0]   bit_cnt;
    logic            parity_err;

    int checks    = 0;
    int errors    = 0;
    int delivered = 0;
    bit sb_on     = 1'b0;
    logic [SIZE-1:0] exp_q[$];

    typedef struct {
        logic            sin;
        logic            sin_valid;
        logic            flush;
        logic            word_ready;
        logic            exp_wv;
        logic [SIZE-1:0] exp_wo;
        logic [CW-1:0]   exp_cnt;
        logic            exp_ovr;
    } vec_t;

    vec_t tbl[FRAME+1];

    serial_deserializer #(.SIZE(SIZE)) dut (
        .clk        (clk),
        .rst        (rst),
        .sin        (sin),
        .sin_valid  (sin_valid),
        .flush      (flush),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .overrun    (overrun),
        .bit_cnt    (bit_cnt),
        .parity_err (parity_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [SIZE-1:0] w, input int max_gap, input bit push,
                             input bit rdy_last, input bit bad_par);
        logic [SIZE:0]  ext;
        logic [FRAME-1:0] f;
        int g;
        ext = {(^w) ^ bad_par, w};
        f   = ext[FRAME-1:0];
        for (int i = 0; i < FRAME; i++) begin
            g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (g) begin
                sin_valid = 1'b0;
                sin       = 1'($urandom);
                cycle();
            end
            sin       = f[i];
            sin_valid = 1'b1;
            if (i == FRAME - 1) begin
                if (push) exp_q.push_back(w);
                if (rdy_last) word_ready = 1'b1;
            end
            cycle();
        end
        sin_valid = 1'b0;
        sin       = 1'b0;
        if (rdy_last) word_ready = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        chk({tag, "_rst_wv"},  32'(word_valid), 32'd0);
        chk({tag, "_rst_wo"},  32'(word_out),   32'd0);
        chk({tag, "_rst_ovr"}, 32'(overrun),    32'd0);
        chk({tag, "_rst_cnt"}, 32'(bit_cnt),    32'd0);
        exp_q.delete();
        cycle();
        rst = 1'b0;
    endtask

    // Scoreboard: a handshake seen mid-cycle retires the oldest expected word
    always @(negedge clk) begin : sb_mon
        logic [SIZE-1:0] e_v;
        if (sb_on && !rst && word_valid && word_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got word %0h expected none", word_out);
            end else begin
                e_v = exp_q.pop_front();
                chk("sb_word", 32'(word_out), 32'(e_v));
                delivered++;
            end
        end
    end

    initial begin : main
        logic [SIZE:0] ext1;
        rst        = 1'b1;
        sin        = 1'b0;
        sin_valid  = 1'b0;
        flush      = 1'b0;
        word_ready = 1'b0;

        ext1 = {1'b0, 10'h20D};
        ext1[SIZE] = ^ext1[SIZE-1:0];
        for (int i = 0; i < FRAME; i++) begin
            tbl[i] = '{sin: ext1[i], sin_valid: 1'b1, flush: 1'b0, word_ready: 1'b0,
                       exp_wv: (i == FRAME - 1),
                       exp_wo: (i == FRAME - 1) ? 10'h20D : 10'h000,
                       exp_cnt: CW'((i + 1) % FRAME), exp_ovr: 1'b0};
        end
        tbl[FRAME] = '{sin: 1'b0, sin_valid: 1'b0, flush: 1'b0, word_ready: 1'b1,
                       exp_wv: 1'b0, exp_wo: 10'h20D, exp_cnt: {CW{1'b0}}, exp_ovr: 1'b0};

        repeat (2) cycle();
        chk("init_wv",   32'(word_valid), 32'd0);
        chk("init_wo",   32'(word_out),   32'd0);
        chk("init_ovr",  32'(overrun),    32'd0);
        chk("init_cnt",  32'(bit_cnt),    32'd0);
        chk("init_perr", 32'(parity_err), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < FRAME + 1; i++) begin
            sin        = tbl[i].sin;
            sin_valid  = tbl[i].sin_valid;
            flush      = tbl[i].flush;
            word_ready = tbl[i].word_ready;
            cycle();
            chk($sformatf("vec%0d_wv", i),  32'(word_valid), 32'(tbl[i].exp_wv));
            chk($sformatf("vec%0d_wo", i),  32'(word_out),   32'(tbl[i].exp_wo));
            chk($sformatf("vec%0d_cnt", i), 32'(bit_cnt),    32'(tbl[i].exp_cnt));
            chk($sformatf("vec%0d_ovr", i), 32'(overrun),    32'(tbl[i].exp_ovr));
        end
        sin_valid  = 1'b0;
        word_ready = 1'b0;

        // Back-to-back words, random gaps, consumer always ready
        sb_on      = 1'b1;
        word_ready = 1'b1;
        send_word(10'h155, 2, 1'b1, 1'b0, 1'b0);
        send_word(10'h2AA, 2, 1'b1, 1'b0, 1'b0);
        repeat (3) cycle();
        chk("b2b_delivered", 32'(delivered),    32'd2);
        chk("b2b_q_empty",   32'(exp_q.size()), 32'd0);
        chk("b2b_ovr",       32'(overrun),      32'd0);
        chk("b2b_wv",        32'(word_valid),   32'd0);

        // Overrun: consumer stalled across three words
        word_ready = 1'b0;
        send_word(10'h001, 0, 1'b1, 1'b0, 1'b0);
        chk("ovr_first_wv",  32'(word_valid), 32'd1);
        chk("ovr_first_ovr", 32'(overrun),    32'd0);
        send_word(10'h002, 0, 1'b0, 1'b0, 1'b0);
        chk("ovr_second_ovr", 32'(overrun),  32'd1);
        chk("ovr_second_wo",  32'(word_out), 32'h001);
        send_word(10'h003, 1, 1'b0, 1'b0, 1'b0);
        chk("ovr_third_wo",  32'(word_out),   32'h001);
        chk("ovr_third_wv",  32'(word_valid), 32'd1);
        word_ready = 1'b1;
        cycle();
        word_ready = 1'b0;
        chk("ovr_drain_wv",  32'(word_valid),   32'd0);
        chk("ovr_q_empty",   32'(exp_q.size()), 32'd0);
        chk("ovr_sticky",    32'(overrun),      32'd1);

        // Completion in FULL coinciding with consumption
        do_reset("sim");
        send_word(10'h0AB, 0, 1'b1, 1'b0, 1'b0);
        chk("sim_first_wv", 32'(word_valid), 32'd1);
        send_word(10'h3FF, 1, 1'b1, 1'b1, 1'b0);
        chk("sim_wo",   32'(word_out),   32'h3FF);
        chk("sim_wv",   32'(word_valid), 32'd1);
        chk("sim_ovr",  32'(overrun),    32'd0);
        chk("sim_perr", 32'(parity_err), 32'd0);
        word_ready = 1'b1;
        cycle();
        word_ready = 1'b0;
        chk("sim_drain_wv", 32'(word_valid),   32'd0);
        chk("sim_q_empty",  32'(exp_q.size()), 32'd0);

        // Flush mid-word with a simultaneous valid bit
        do_reset("fl");
        for (int i = 0; i < 6; i++) begin
            sin       = 1'b1;
            sin_valid = 1'b1;
            cycle();
        end
        chk("fl_cnt6", 32'(bit_cnt), 32'd6);
        sin       = 1'b1;
        sin_valid = 1'b1;
        flush     = 1'b1;
        cycle();
        flush     = 1'b0;
        sin_valid = 1'b0;
        chk("fl_cnt0", 32'(bit_cnt),    32'd0);
        chk("fl_wv",   32'(word_valid), 32'd0);
        send_word(10'h0F0, 0, 1'b1, 1'b0, 1'b0);
        chk("fl_wo",  32'(word_out),   32'h0F0);
        chk("fl_wv2", 32'(word_valid), 32'd1);
        chk("fl_cnt", 32'(bit_cnt),    32'd0);

        // Asynchronous reset at bit 4 of the next word, output still full
        for (int i = 0; i < 4; i++) begin
            sin       = 1'(i & 1);
            sin_valid = 1'b1;
            cycle();
        end
        sin_valid = 1'b0;
        chk("mid_cnt4", 32'(bit_cnt), 32'd4);
        do_reset("mid");

`ifdef SERIAL_PARITY_CHECK_EN
        // Parity: good then corrupted parity bit on the same data
        send_word(10'h007, 0, 1'b1, 1'b0, 1'b0);
        chk("par_good_perr", 32'(parity_err), 32'd0);
        chk("par_good_wo",   32'(word_out),   32'h007);
        word_ready = 1'b1;
        cycle();
        word_ready = 1'b0;
        send_word(10'h007, 0, 1'b1, 1'b0, 1'b1);
        chk("par_bad_perr", 32'(parity_err), 32'd1);
        chk("par_bad_wo",   32'(word_out),   32'h007);
        chk("par_bad_wv",   32'(word_valid), 32'd1);
        word_ready = 1'b1;
        cycle();
        word_ready = 1'b0;
`endif

        sb_on = 1'b0;
        chk("final_q_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_deserializer.md
Name: serial_deserializer

Overview:
- Receiver end of the team's serial shift chain: collects a qualified serial bit stream into SIZE-bit parallel words.
- Internal shift stage plus one output holding register, so a following word can be received while the previous word awaits handoff.
- Sits downstream of a shift_register-style serializer; presents words to a consumer over a valid/ready handshake.

Parameters:
- SIZE, 10, data bits per word (minimum 2).

Ports:
- clk  input  1  sole clock; all state changes on posedge clk.
- rst  input  1  asynchronous, active-high reset.
- sin  input  1  serial data bit.
- sin_valid  input  1  sin is sampled only on cycles where this is 1.
- flush  input  1  synchronous abort of the partially received word.
- word_out  output  SIZE  assembled word, bit 0 = first bit received (LSB-first).
- word_valid  output  1  word_out holds an unconsumed word.
- word_ready  input  1  consumer accepts word_out when word_valid && word_ready.
- overrun  output  1  sticky flag: a completed word was dropped.
- bit_cnt  output  $clog2(SIZE)  number of bits of the current partial word.

Behaviour:
- Reset (async, immediate): shift stage = 0, bit_cnt = 0, word_out = 0, word_valid = 0, overrun = 0. Reset mid-word discards all partial bits.
- Shifting: on posedge with sin_valid = 1, sin enters at the MSB end of the shift stage and the stage shifts toward bit 0. bit_cnt increments. Cycles with sin_valid = 0 leave all state unchanged.
- Completion: the SIZE-th valid bit is the cycle with bit_cnt == SIZE-1 and sin_valid = 1. On that edge:
  - bit_cnt wraps to 0.
  - The full word, including that final bit, is transferred to the output register if it is free.
- Latency: word_valid rises on the same edge that samples the final bit. There are no gap cycles between words; bit 0 of the next word may arrive on the following cycle.
- Output FSM, two states:
  - EMPTY (word_valid = 0): on completion, load word_out and go to FULL.
  - FULL (word_valid = 1): on word_valid && word_ready, go to EMPTY, unless completion occurs the same cycle.
  - Simultaneous completion and word_ready in FULL: the new word is loaded, state stays FULL, no overrun.
  - Completion in FULL without word_ready: the new word is discarded, word_out is unchanged, overrun is set.
- overrun: once set, it stays 1 until rst.
- word_out: stable while word_valid = 1 and not yet consumed. It holds its last value in EMPTY.
- flush:
  - Clears the shift stage and bit_cnt to 0.
  - Has no effect on word_out, word_valid or overrun.
  - flush has priority over sin_valid in the same cycle; that bit is dropped.
- word_ready while EMPTY is ignored.

Optional Feature:
- Macro: SERIAL_PARITY_CHECK_EN.
- Defined:
  - Each frame is SIZE+1 valid bits. The extra final bit is even parity over the SIZE data bits.
  - bit_cnt width becomes $clog2(SIZE+1).
  - Completion occurs on the parity bit.
  - Output port parity_err (1 bit) is registered with word_out: 1 if the XOR of data bits and parity bit is 1. It is cleared with word_out by rst.
  - Words with a parity error are still delivered.
- Not defined:
  - Frames are SIZE bits.
  - parity_err port is still present, tied to 0.

Decomposition:
- Package serial_pkg: typedef enum {EMPTY, FULL} out_state_t; the bit-counter width constant function; the even-parity helper function.
- One sub-module, serial_bit_counter:
  - Modulo-N counter with enable and synchronous clear; asynchronous active-high rst.
  - Outputs count and a wrap pulse.
  - Instantiated once to produce bit_cnt and the completion strobe.

Test Plan (SIZE=10, macro undefined unless stated):
- rst held, then released; send 10 valid bits 1,0,1,1,0,0,0,0,0,1 -> word_valid=1 on the 10th sampling edge, word_out=10'h20D; word_ready=1 one cycle -> word_valid=0.
- Two back-to-back words 10'h155 then 10'h2AA with sin_valid gapped randomly, word_ready held 1 -> both delivered in order, overrun stays 0.
- word_ready held 0, send three full words 10'h001, 10'h002, 10'h003 -> word_out stays 10'h001, overrun=1 after the second word completes; then word_ready=1 -> 10'h001 consumed, word_valid=0.
- Word 10'h3FF complete in FULL on the same cycle word_ready=1 -> word_out=10'h3FF, word_valid stays 1, overrun=0.
- Send 6 bits, pulse flush together with sin_valid, then 10 bits of 10'h0F0 -> word_out=10'h0F0, bit_cnt=0 after flush. Assert rst mid-word at bit 4 -> all outputs 0 immediately.
- SERIAL_PARITY_CHECK_EN: frame 10'h007 with parity bit 1 -> parity_err=0; same data with parity bit 0 -> parity_err=1, word_out=10'h007.
